// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first, with 16x (OVERSAMPLE) mid-bit sampling.
//
// The oversampling tick is derived from clk_i by dividing by
// DIV = FREQ/(BAUD_RATE*OVERSAMPLE). BAUD_RATE and FREQ are the same
// parameters the transmit side uses, so both ends agree on bit timing.
// OVERSAMPLE must be even and >= 4, and DIV must be >= 2.
//
// Ports:
//   clk_i          system clock, rising edge
//   srst_i         asynchronous active-high reset
//   rx_i           asynchronous serial line, idle high
//   rx_data_o      last received byte, held until the next frame completes
//   data_valid_o   one-cycle pulse when a frame ends with a good stop bit
//   framing_err_o  one-cycle pulse when the stop bit is sampled low
//   busy_o         high whenever the receiver is not idle
//
// States:
//   IDLE  | waiting for a falling edge on the synchronised line
//   START | timing to mid start bit to confirm it is still low
//   DATA  | sampling 8 data bits, one every OVERSAMPLE ticks
//   STOP  | sampling the stop bit, then reporting the byte
module uart_rx #(
  parameter int BAUD_RATE  = 2400,
  parameter int FREQ       = 1000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       data_valid_o,
  output logic       framing_err_o,
  output logic       busy_o
);

  localparam int DIV    = FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCNT_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TCNT_W-1:0] TC_MID   = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] TC_LAST  = TCNT_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q;
  logic              rx_meta_q;
  logic              rx_s_q;
  logic              rx_prev_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic [2:0]        bcnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic [7:0]        rx_data_q;
  logic              data_valid_q;
  logic              framing_err_q;
  logic              busy_q;
  logic              tick;
  logic              start_edge;

  // Synchroniser plus one history flop; all reset high so that leaving
  // reset can never look like a falling edge.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // A line held low (break) produces no new edge, so no restart until it
  // has gone high and fallen again.
  assign start_edge = rx_prev_q & ~rx_s_q;
  assign tick       = (div_cnt_q == DIV_LAST);
  assign shift_d    = {rx_s_q, shift_q[7:1]};

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      tcnt_q        <= '0;
      bcnt_q        <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;

      if (state_q == IDLE || tick) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end

      if (tick) begin
        tcnt_q <= tcnt_q + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q   <= START;
            busy_q    <= 1'b1;
            tcnt_q    <= '0;
            div_cnt_q <= '0;
          end
        end

        START: begin
          if (tick && tcnt_q == TC_MID) begin
            if (!rx_s_q) begin
              state_q <= DATA;
              tcnt_q  <= '0;
              bcnt_q  <= '0;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        DATA: begin
          if (tick && tcnt_q == TC_LAST) begin
            shift_q <= shift_d;
            if (bcnt_q == 3'd7) begin
              state_q <= STOP;
              tcnt_q  <= '0;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick && tcnt_q == TC_LAST) begin
            rx_data_q     <= shift_q;
            data_valid_q  <= rx_s_q;
            framing_err_q <= ~rx_s_q;
            state_q       <= IDLE;
            busy_q        <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data_o     = rx_data_q;
  assign data_valid_o  = data_valid_q;
  assign framing_err_o = framing_err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (DIV=26, 416 clocks/bit).
// Timing reference: if rx_i falls at the negedge inside cycle n, the start
// edge is seen in cycle n+2, busy rises in cycle n+3, and the stop-sample
// result (pulse, new rx_data, busy fall) is visible in cycle n+2+152*26+1.
module tb_uart_rx;

  logic       clk_i;
  logic       srst_i;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       data_valid_o;
  logic       framing_err_o;
  logic       busy_o;

  int n_cmp;
  int n_fail;

  int cyc;
  int valid_cnt, ferr_cnt, both_cnt, busy_rises;
  int last_valid_cyc, last_ferr_cyc, busy_rise_cyc, busy_fall_cyc;
  logic [7:0] last_valid_data, last_ferr_data;
  logic busy_prev;
  logic [7:0] valid_data_q[$];
  int         valid_cyc_q[$];
  int         frame_start_cyc;

  localparam int BIT = 416;
  localparam int STOP_LAT = 2 + 152 * 26 + 1;

  uart_rx dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .data_valid_o (data_valid_o),
    .framing_err_o(framing_err_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc = cyc + 1;

  // Passive recorder of output events, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (data_valid_o) begin
      valid_cnt = valid_cnt + 1;
      last_valid_data = rx_data_o;
      last_valid_cyc = cyc;
      valid_data_q.push_back(rx_data_o);
      valid_cyc_q.push_back(cyc);
    end
    if (framing_err_o) begin
      ferr_cnt = ferr_cnt + 1;
      last_ferr_data = rx_data_o;
      last_ferr_cyc = cyc;
    end
    if (data_valid_o && framing_err_o) both_cnt = both_cnt + 1;
    if (busy_o && !busy_prev) begin
      busy_rises = busy_rises + 1;
      busy_rise_cyc = cyc;
    end
    if (!busy_o && busy_prev) busy_fall_cyc = cyc;
    busy_prev = busy_o;
  end

  // Called at a negedge; drives start, 8 data bits LSB first, and stop.
  task automatic send_frame(input logic [7:0] b, input int bitclks, input logic stop_v);
    rx_i = 1'b0;
    frame_start_cyc = cyc;
    repeat (bitclks) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (bitclks) @(negedge clk_i);
    end
    rx_i = stop_v;
    repeat (bitclks) @(negedge clk_i);
  endtask

  task automatic test_reset();
    srst_i = 1'b1;
    rx_i = 1'b1;
    #1;
    n_cmp++;
    if ({rx_data_o, data_valid_o, framing_err_o, busy_o} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h/%b/%b/%b want 00/0/0/0", rx_data_o, data_valid_o, framing_err_o, busy_o);
    end
    repeat (5) @(negedge clk_i);
    srst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    n_cmp++;
    if ({rx_data_o, data_valid_o, framing_err_o, busy_o} !== 11'h000 || valid_cnt != 0 || ferr_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h/%b/%b/%b vcnt=%0d fcnt=%0d want 00/0/0/0 0 0", rx_data_o, data_valid_o, framing_err_o, busy_o, valid_cnt, ferr_cnt);
    end
  endtask

  task automatic test_byte();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    send_frame(8'hA5, BIT, 1'b1);
    repeat (50) @(negedge clk_i);
    n_cmp++;
    if (valid_cnt - v0 != 1 || ferr_cnt != f0) begin
      n_fail++;
      $display("FAIL byte_pulses: got valid=%0d ferr=%0d want 1 0", valid_cnt - v0, ferr_cnt - f0);
    end
    n_cmp++;
    if (last_valid_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL byte_data: got %h want a5", last_valid_data);
    end
    n_cmp++;
    if (last_valid_cyc != frame_start_cyc + STOP_LAT) begin
      n_fail++;
      $display("FAIL byte_latency: got %0d want %0d", last_valid_cyc - frame_start_cyc, STOP_LAT);
    end
    n_cmp++;
    if (busy_rise_cyc != frame_start_cyc + 3 || busy_fall_cyc - busy_rise_cyc != 3952) begin
      n_fail++;
      $display("FAIL byte_busy: got rise=+%0d len=%0d want +3 3952", busy_rise_cyc - frame_start_cyc, busy_fall_cyc - busy_rise_cyc);
    end
    n_cmp++;
    if (rx_data_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL byte_hold: got %h want a5", rx_data_o);
    end
  endtask

  task automatic test_false_start();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    int b0 = busy_rises;
    rx_i = 1'b0;
    frame_start_cyc = cyc;
    repeat (150) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (600) @(negedge clk_i);
    n_cmp++;
    if (busy_rises - b0 != 1 || busy_rise_cyc != frame_start_cyc + 3 || busy_fall_cyc - busy_rise_cyc != 208) begin
      n_fail++;
      $display("FAIL false_start_busy: got rises=%0d rise=+%0d len=%0d want 1 +3 208", busy_rises - b0, busy_rise_cyc - frame_start_cyc, busy_fall_cyc - busy_rise_cyc);
    end
    n_cmp++;
    if (valid_cnt != v0 || ferr_cnt != f0 || rx_data_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL false_start_quiet: got valid=%0d ferr=%0d data=%h want 0 0 a5", valid_cnt - v0, ferr_cnt - f0, rx_data_o);
    end
  endtask

  task automatic test_framing_error();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    int b0 = busy_rises;
    send_frame(8'h3C, BIT, 1'b0);
    repeat (2000) @(negedge clk_i);
    n_cmp++;
    if (ferr_cnt - f0 != 1 || valid_cnt != v0 || last_ferr_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL ferr_pulse: got ferr=%0d valid=%0d data=%h want 1 0 3c", ferr_cnt - f0, valid_cnt - v0, last_ferr_data);
    end
    n_cmp++;
    if (last_ferr_cyc != frame_start_cyc + STOP_LAT) begin
      n_fail++;
      $display("FAIL ferr_latency: got %0d want %0d", last_ferr_cyc - frame_start_cyc, STOP_LAT);
    end
    n_cmp++;
    if (busy_rises - b0 != 1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_break_norestart: got rises=%0d busy=%b want 1 0", busy_rises - b0, busy_o);
    end
    rx_i = 1'b1;
    repeat (BIT) @(negedge clk_i);
    send_frame(8'h81, BIT, 1'b1);
    repeat (50) @(negedge clk_i);
    n_cmp++;
    if (valid_cnt - v0 != 1 || last_valid_data !== 8'h81 || ferr_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL ferr_recover: got valid=%0d data=%h ferr=%0d want 1 81 1", valid_cnt - v0, last_valid_data, ferr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int q0 = valid_data_q.size();
    int f0 = ferr_cnt;
    int s0;
    send_frame(8'h00, BIT, 1'b1);
    s0 = frame_start_cyc;
    send_frame(8'hFF, BIT, 1'b1);
    send_frame(8'h55, BIT, 1'b1);
    repeat (50) @(negedge clk_i);
    n_cmp++;
    if (valid_data_q.size() - q0 != 3 || ferr_cnt != f0) begin
      n_fail++;
      $display("FAIL b2b_count: got valid=%0d ferr=%0d want 3 0", valid_data_q.size() - q0, ferr_cnt - f0);
    end else begin
      n_cmp++;
      if (valid_data_q[q0] !== 8'h00 || valid_data_q[q0+1] !== 8'hFF || valid_data_q[q0+2] !== 8'h55) begin
        n_fail++;
        $display("FAIL b2b_data: got %h %h %h want 00 ff 55", valid_data_q[q0], valid_data_q[q0+1], valid_data_q[q0+2]);
      end
      n_cmp++;
      if (valid_cyc_q[q0] != s0 + STOP_LAT || valid_cyc_q[q0+1] - valid_cyc_q[q0] != 4160 || valid_cyc_q[q0+2] - valid_cyc_q[q0+1] != 4160) begin
        n_fail++;
        $display("FAIL b2b_spacing: got +%0d %0d %0d want +%0d 4160 4160", valid_cyc_q[q0] - s0, valid_cyc_q[q0+1] - valid_cyc_q[q0], valid_cyc_q[q0+2] - valid_cyc_q[q0+1], STOP_LAT);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    logic [7:0] b = 8'hF0;
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      rx_i = b[i];
      repeat (BIT) @(negedge clk_i);
    end
    rx_i = b[3];
    repeat (200) @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy_before: got %b want 1", busy_o);
    end
    srst_i = 1'b1;
    #1;
    n_cmp++;
    if ({rx_data_o, data_valid_o, framing_err_o, busy_o} !== 11'h000) begin
      n_fail++;
      $display("FAIL midrst_async: got %h/%b/%b/%b want 00/0/0/0", rx_data_o, data_valid_o, framing_err_o, busy_o);
    end
    rx_i = 1'b1;
    repeat (5) @(negedge clk_i);
    srst_i = 1'b0;
    repeat (BIT) @(negedge clk_i);
    n_cmp++;
    if (valid_cnt != v0 || ferr_cnt != f0 || rx_data_o !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_quiet: got valid=%0d ferr=%0d data=%h want 0 0 00", valid_cnt - v0, ferr_cnt - f0, rx_data_o);
    end
    send_frame(8'h12, BIT, 1'b1);
    repeat (50) @(negedge clk_i);
    n_cmp++;
    if (valid_cnt - v0 != 1 || last_valid_data !== 8'h12 || ferr_cnt != f0) begin
      n_fail++;
      $display("FAIL midrst_next: got valid=%0d data=%h ferr=%0d want 1 12 0", valid_cnt - v0, last_valid_data, ferr_cnt - f0);
    end
  endtask

  task automatic test_baud_tolerance();
    int periods[2] = '{400, 432};
    for (int k = 0; k < 2; k++) begin
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      send_frame(8'h6B, periods[k], 1'b1);
      repeat (100) @(negedge clk_i);
      n_cmp++;
      if (valid_cnt - v0 != 1 || last_valid_data !== 8'h6B || ferr_cnt != f0) begin
        n_fail++;
        $display("FAIL baud_%0d: got valid=%0d data=%h ferr=%0d want 1 6b 0", periods[k], valid_cnt - v0, last_valid_data, ferr_cnt - f0);
      end
    end
    n_cmp++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", both_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    valid_cnt = 0;
    ferr_cnt = 0;
    both_cnt = 0;
    busy_rises = 0;
    last_valid_cyc = 0;
    last_ferr_cyc = 0;
    busy_rise_cyc = 0;
    busy_fall_cyc = 0;
    last_valid_data = 8'h00;
    last_ferr_data = 8'h00;
    busy_prev = 1'b0;
    frame_start_cyc = 0;
    test_reset();
    test_byte();
    test_false_start();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_tolerance();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames, LSB first. It samples the asynchronous `rx` line using an internal 16x oversampling tick derived from the system clock. Each byte it recovers is presented with a one-cycle valid strobe. It is the receive-side counterpart of the transmit path clocked by `baud_generator`, and uses the same `FREQ`/`BAUD_RATE` parameterisation so that both ends agree on bit timing.

## Interface
- `BAUD_RATE`, default 2400: line rate in bits/s.
- `FREQ`, default 1000000: system clock frequency in Hz.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥ 4.
- Derived `DIV = FREQ/(BAUD_RATE*OVERSAMPLE)` (integer division, 26 at defaults). Must be ≥ 2.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `srst` input, 1 bit: reset. It is asynchronous and active-high.
- `rx` input, 1 bit: serial line, asynchronous. Idle level is high.
- `rx_data` output, 8 bits: last received byte.
- `data_valid` output, 1 bit: one-cycle pulse when a good frame completes.
- `framing_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `busy` output, 1 bit: high while a frame is being received, i.e. in any state other than IDLE.

## Operation
- Synchroniser: `rx` passes through 2 flops to give `rx_s`. A third flop holds `rx_d`, the previous value of `rx_s`. All three flops reset to 1, so reset never produces a false edge.
- Start edge: the cycle in which `rx_d==1 && rx_s==0`.
- Tick divider: `div_cnt` counts 0..DIV-1. `tick` is asserted for the one cycle in which `div_cnt==DIV-1`. `div_cnt` holds at 0 in IDLE. On start-edge detection it is cleared so that it starts counting on the next cycle.
- Tick counter: `tcnt` is 4 bits wide (log2 OVERSAMPLE bits). It increments on `tick` and wraps.
- Bit counter: `bcnt` is 3 bits wide and counts 0..7.
- FSM states:
  - IDLE: on a start edge, go to START and clear `tcnt`/`div_cnt`. Otherwise stay.
  - START: on the tick at which `tcnt==OVERSAMPLE/2-1` (the 8th tick, mid start bit), sample `rx_s`.
    - If 0: go to DATA and clear `tcnt` and `bcnt`.
    - If 1: the start was false; go to IDLE with no output pulse.
  - DATA: on every OVERSAMPLE-th tick (`tcnt==OVERSAMPLE-1`), shift `rx_s` into bit 7 of the shift register and shift the register right, so the LSB arrives first.
    - On the sample with `bcnt==7`, go to STOP and clear `tcnt`.
    - Otherwise increment `bcnt`.
  - STOP: on the OVERSAMPLE-th tick, sample `rx_s`. Load `rx_data` from the shift register in either case.
    - If 1: pulse `data_valid`.
    - If 0: pulse `framing_err`.
    - Go to IDLE in both cases.
- After a framing error with the line held low (break condition), no new frame starts until `rx_s` returns high and then falls again. The edge-detect rule enforces this.
- `rx_data` holds its value until the next frame completes. There is no read handshake. A consumer that misses the pulse loses the byte. Overrun is not flagged.
- `data_valid` and `framing_err` are never high in the same cycle.

## Timing
- Reset values: `rx_data`=0x00, `data_valid`=0, `framing_err`=0, `busy`=0, FSM=IDLE, all counters 0.
- Reset is asynchronous. Asserting `srst` mid-frame aborts the frame immediately. No pulse is produced and `rx_data` is unchanged from 0x00 after reset.
- Edge-to-detect latency: a falling `rx` becomes visible at the start-edge detect 2–3 clocks later, depending on the synchroniser phase.
- `busy` rises the cycle after start-edge detection and falls the cycle after the stop sample.
- Sample instants, measured from the start-edge cycle T0 (tick k occurs at T0 + k·DIV):
  - start bit: tick 8
  - data bit i (i=0..7): tick 8+16·(i+1)
  - stop bit: tick 152
- `data_valid`/`framing_err` and the new `rx_data` are visible in the cycle after the stop sample tick, i.e. at T0 + 152·DIV + 1. Each pulse lasts exactly 1 cycle.
- At defaults the bit period is 416 clocks and a frame is 4160 clocks. A new start edge is accepted from the first cycle back in IDLE, so back-to-back frames with a single stop bit are supported.
- The per-bit timing error allowed by sampling at mid-bit is ±(OVERSAMPLE/2−1)/OVERSAMPLE bit over the frame, which is about ±4% at 16x.

## Test plan
- Byte reception: send 0xA5 at 416 clocks/bit → exactly one `data_valid` pulse, `rx_data`=0xA5, `framing_err` stays 0, `busy` high for about 3952 clocks.
- False start: drive `rx` low for 150 clocks, then high → `busy` pulses, then returns to 0 at the tick-8 sample (about 208 clocks), with no `data_valid` or `framing_err`.
- Framing error: send 0x3C with the stop bit low, then hold low for 2000 clocks, then release and send 0x81 → `framing_err` pulse with `rx_data`=0x3C, no restart while the line is held low, then `data_valid` with `rx_data`=0x81.
- Back-to-back frames: send 0x00, 0xFF, 0x55 with one stop bit each and no idle gap → three `data_valid` pulses spaced 4160 clocks apart, with `rx_data` equal to each byte in order.
- Reset mid-frame: assert `srst` during data bit 3 of 0xF0 → outputs return to reset values immediately, no pulse, and a following 0x12 is received correctly.
- Baud tolerance: send 0x6B with the bit period at 400 and at 432 clocks → `data_valid` with `rx_data`=0x6B in both runs.
